alu_issue_stage: RTL and testbench

- ID/EX pipeline register and operand-issue front end for the 32-bit EX-stage ALU (2-bit ALUOp: 00 OR, 01 ADD, 10 MUL, 11 unsigned set-if-less-or-equal).
- Captures decoded instructions from ID and presents op1, op2 and alu_op to the ALU.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and by a one-cycle load-use stall.
- This block is the initiator side of the ALU operand interface; the ALU is purely combinational.

---
 rtl/alu_issue_stage.sv | 164 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register and operand-issue front end for the EX-stage ALU.
// Optional build macro ORI_ZERO_EXT_EN: zero-extend the immediate for OR-with-immediate.
module alu_issue_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  // decoded instruction from ID
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [IMM_W-1:0]  id_imm,
  input  logic              id_use_imm,
  input  logic [1:0]        id_alu_op,
  input  logic              id_mem_read,
  input  logic              id_reg_write,
  input  logic              flush,
  // forwarding sources
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  // ALU operand interface and EX-stage control
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic [1:0]        alu_op,
  output logic              ex_valid,
  output logic              ex_mem_read,
  output logic              ex_reg_write,
  output logic [REG_AW-1:0] ex_rd,
  output logic              stall
);

  typedef enum logic [1:0] {
    ALU_OR  = 2'b00,
    ALU_ADD = 2'b01,
    ALU_MUL = 2'b10,
    ALU_SLE = 2'b11
  } alu_op_e;

  // ID/EX state
  logic              valid_q,     valid_d;
  logic [REG_AW-1:0] rs_q,        rs_d;
  logic [REG_AW-1:0] rt_q,        rt_d;
  logic [REG_AW-1:0] rd_q,        rd_d;
  logic [DATA_W-1:0] rs_data_q,   rs_data_d;
  logic [DATA_W-1:0] rt_data_q,   rt_data_d;
  logic [DATA_W-1:0] ext_imm_q,   ext_imm_d;
  logic              use_imm_q,   use_imm_d;
  logic [1:0]        alu_op_q,    alu_op_d;
  logic              mem_read_q,  mem_read_d;
  logic              reg_write_q, reg_write_d;

  logic              hazard;
  logic              bubble;
  logic              ori_zero_ext;
  logic [DATA_W-1:0] ext_imm;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;

  // Load-use: the loaded value is not available until MEM, so a dependent
  // instruction in ID must wait one cycle behind a bubble.
  always_comb begin
    hazard = valid_q && mem_read_q && (rd_q != '0) && id_valid &&
             ((id_rs == rd_q) || (!id_use_imm && (id_rt == rd_q)));
    stall  = hazard && !flush;
    bubble = hazard || flush;
  end

  always_comb begin
`ifdef ORI_ZERO_EXT_EN
    ori_zero_ext = id_use_imm && (alu_op_e'(id_alu_op) == ALU_OR);
`else
    ori_zero_ext = 1'b0;
`endif
    if (ori_zero_ext) begin
      ext_imm = {{(DATA_W-IMM_W){1'b0}}, id_imm};
    end else begin
      ext_imm = {{(DATA_W-IMM_W){id_imm[IMM_W-1]}}, id_imm};
    end
  end

  // Data fields load unconditionally; only the control bits are squashed
  // for a bubble, since a bubble's data is never consumed.
  always_comb begin
    valid_d     = id_valid     && !bubble;
    mem_read_d  = id_mem_read  && !bubble;
    reg_write_d = id_reg_write && !bubble;
    rs_d        = id_rs;
    rt_d        = id_rt;
    rd_d        = id_rd;
    rs_data_d   = id_rs_data;
    rt_data_d   = id_rt_data;
    ext_imm_d   = ext_imm;
    use_imm_d   = id_use_imm;
    alu_op_d    = id_alu_op;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: data registers are cleared too so ex_rd/alu_op read a defined
      // zero straight out of reset.
      valid_q     <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      ext_imm_q   <= '0;
      use_imm_q   <= 1'b0;
      alu_op_q    <= 2'b00;
      mem_read_q  <= 1'b0;
      reg_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      ext_imm_q   <= ext_imm_d;
      use_imm_q   <= use_imm_d;
      alu_op_q    <= alu_op_d;
      mem_read_q  <= mem_read_d;
      reg_write_q <= reg_write_d;
    end
  end

  // EX/MEM is younger than MEM/WB, so it wins; r0 is hardwired and never forwarded.
  function automatic logic [DATA_W-1:0] forward(input logic [REG_AW-1:0] idx,
                                                input logic [DATA_W-1:0] rf_data);
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == idx)) begin
      return exmem_result;
    end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == idx)) begin
      return memwb_result;
    end else begin
      return rf_data;
    end
  endfunction

  // NOTE: every combinational output is assigned on every path so no latch is inferred.
  always_comb begin
    src1 = forward(rs_q, rs_data_q);
    src2 = forward(rt_q, rt_data_q);
    op1  = src1;
    op2  = use_imm_q ? ext_imm_q : src2;
  end

  assign alu_op       = alu_op_q;
  assign ex_valid     = valid_q;
  assign ex_mem_read  = mem_read_q;
  assign ex_reg_write = reg_write_q;
  assign ex_rd        = rd_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed plus randomized bench for alu_issue_stage against an instruction-level model.
// Honours ORI_ZERO_EXT_EN when the build defines it.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data;
  logic [15:0] id_imm;
  logic        id_use_imm;
  logic [1:0]  id_alu_op;
  logic        id_mem_read, id_reg_write, flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] op1, op2;
  logic [1:0]  alu_op;
  logic        ex_valid, ex_mem_read, ex_reg_write, stall;
  logic [4:0]  ex_rd;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_alu_op(id_alu_op), .id_mem_read(id_mem_read),
    .id_reg_write(id_reg_write), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .op1(op1), .op2(op2), .alu_op(alu_op), .ex_valid(ex_valid),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd), .stall(stall)
  );

  // The instruction currently sitting in EX, as the program sees it.
  typedef struct {
    bit        valid, mem_read, reg_write, use_imm;
    bit [4:0]  rs, rt, rd;
    bit [31:0] rs_data, rt_data, imm;
    bit [1:0]  op;
  } slot_t;
  slot_t slot;

  function automatic bit [31:0] imm_value(bit [15:0] imm, bit [1:0] op, bit use_imm);
`ifdef ORI_ZERO_EXT_EN
    if (use_imm && op == 2'b00) return 32'(imm);
`endif
    return int'($signed(imm));
  endfunction

  // Value the program expects for register idx: newest in-flight write wins.
  function automatic bit [31:0] reg_value(bit [4:0] idx, bit [31:0] rf);
    if (idx == 0) return rf;
    if (exmem_reg_write && exmem_rd == idx) return exmem_result;
    if (memwb_reg_write && memwb_rd == idx) return memwb_result;
    return rf;
  endfunction

  function automatic bit must_wait();
    bit reads_load = (id_rs == slot.rd) || (!id_use_imm && id_rt == slot.rd);
    return slot.valid && slot.mem_read && slot.rd != 0 && id_valid && reads_load;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit hz;
    @(posedge clk);
    hz = must_wait();
    if (rst) begin
      slot = '{default: 0};
    end else if (hz || flush) begin
      slot.valid = 0; slot.mem_read = 0; slot.reg_write = 0;
    end else begin
      slot.valid = id_valid;       slot.mem_read = id_mem_read;
      slot.reg_write = id_reg_write; slot.use_imm = id_use_imm;
      slot.rs = id_rs; slot.rt = id_rt; slot.rd = id_rd;
      slot.rs_data = id_rs_data; slot.rt_data = id_rt_data;
      slot.imm = imm_value(id_imm, id_alu_op, id_use_imm);
      slot.op = id_alu_op;
    end
    #1;
  endtask

  task automatic id_set(bit v, bit [4:0] rs, bit [4:0] rt, bit [4:0] rd,
                        bit [31:0] rsd, bit [31:0] rtd, bit [15:0] imm,
                        bit ui, bit [1:0] op, bit mr, bit rw);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_use_imm = ui; id_alu_op = op; id_mem_read = mr; id_reg_write = rw;
  endtask

  task automatic check_model(string tag);
    check({tag, ".stall"}, 32'(stall), 32'(must_wait() && !flush));
    check({tag, ".ex_valid"}, 32'(ex_valid), 32'(slot.valid));
    check({tag, ".ex_reg_write"}, 32'(ex_reg_write), 32'(slot.reg_write));
    check({tag, ".ex_mem_read"}, 32'(ex_mem_read), 32'(slot.mem_read));
    if (slot.valid) begin
      check({tag, ".ex_rd"}, 32'(ex_rd), 32'(slot.rd));
      check({tag, ".alu_op"}, 32'(alu_op), 32'(slot.op));
      check({tag, ".op1"}, op1, reg_value(slot.rs, slot.rs_data));
      check({tag, ".op2"}, op2, slot.use_imm ? slot.imm : reg_value(slot.rt, slot.rt_data));
    end
  endtask

  task automatic randomize_fwd();
    exmem_reg_write = 1'($urandom_range(0, 1));
    exmem_rd        = 5'($urandom_range(0, 7));
    exmem_result    = $urandom;
    memwb_reg_write = 1'($urandom_range(0, 1));
    memwb_rd        = 5'($urandom_range(0, 7));
    memwb_result    = $urandom;
    flush           = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    bit hold;
    rst = 1'b1; flush = 1'b0;
    id_set(1, 1, 2, 3, 32'h1, 32'h2, 16'h0, 0, 2'b10, 1, 1);
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;

    // reset held two cycles with a live instruction in ID
    tick(); tick();
    check("rst.ex_valid", 32'(ex_valid), 32'd0);
    check("rst.ex_reg_write", 32'(ex_reg_write), 32'd0);
    check("rst.ex_mem_read", 32'(ex_mem_read), 32'd0);
    check("rst.ex_rd", 32'(ex_rd), 32'd0);
    check("rst.alu_op", 32'(alu_op), 32'd0);
    rst = 1'b0;
    check("rst.stall", 32'(stall), 32'd0);

    // plain issue
    id_set(1, 1, 2, 3, 32'd5, 32'd7, 16'h0, 0, 2'b01, 0, 1);
    tick();
    check("issue.op1", op1, 32'd5);
    check("issue.op2", op2, 32'd7);
    check("issue.alu_op", 32'(alu_op), 32'd1);
    check("issue.ex_rd", 32'(ex_rd), 32'd3);
    check("issue.ex_valid", 32'(ex_valid), 32'd1);

    // forwarding priority
    id_set(1, 4, 0, 9, 32'h99, 32'h0, 16'h0, 0, 2'b01, 0, 1);
    tick();
    exmem_reg_write = 1; exmem_rd = 4; exmem_result = 32'h11;
    memwb_reg_write = 1; memwb_rd = 4; memwb_result = 32'h22;
    #1 check("fwd.exmem", op1, 32'h11);
    exmem_reg_write = 0;
    #1 check("fwd.memwb", op1, 32'h22);
    id_set(1, 0, 0, 9, 32'h55, 32'h0, 16'h0, 0, 2'b01, 0, 1);
    tick();
    exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0;
    #1 check("fwd.r0", op1, 32'h55);
    exmem_reg_write = 0; memwb_reg_write = 0;

    // load-use on rs: one bubble, then the held instruction re-issues
    id_set(1, 1, 2, 8, 32'h0, 32'h0, 16'h0, 0, 2'b01, 1, 1);
    tick();
    id_set(1, 8, 2, 5, 32'h0, 32'h0, 16'h0, 0, 2'b01, 0, 1);
    #1 check("lu.stall", 32'(stall), 32'd1);
    tick();
    check("lu.bubble", 32'(ex_valid), 32'd0);
    check("lu.stall_len", 32'(stall), 32'd0);
    tick();
    check("lu.reissue_valid", 32'(ex_valid), 32'd1);
    check("lu.reissue_rd", 32'(ex_rd), 32'd5);

    // rt matches the load but rt is not read when the immediate is used
    id_set(1, 1, 2, 8, 32'h0, 32'h0, 16'h0, 0, 2'b01, 1, 1);
    tick();
    id_set(1, 1, 8, 6, 32'h0, 32'h0, 16'h0, 1, 2'b01, 0, 1);
    #1 check("lu.imm_no_stall", 32'(stall), 32'd0);
    id_use_imm = 0;
    #1 check("lu.rt_stall", 32'(stall), 32'd1);
    flush = 1;
    #1 check("flush.stall", 32'(stall), 32'd0);
    tick();
    check("flush.ex_valid", 32'(ex_valid), 32'd0);
    flush = 0;

    // immediate extension
    id_set(1, 1, 2, 7, 32'h0, 32'h0, 16'hFFFF, 1, 2'b00, 0, 1);
    tick();
`ifdef ORI_ZERO_EXT_EN
    check("imm.or", op2, 32'h0000_FFFF);
`else
    check("imm.or", op2, 32'hFFFF_FFFF);
`endif
    id_alu_op = 2'b01;
    tick();
    check("imm.add", op2, 32'hFFFF_FFFF);

    // randomized traffic; ID is held while the model says it must wait
    hold = 0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        id_set(($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), $urandom, $urandom, 16'($urandom),
               1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
      end
      randomize_fwd();
      #1 check_model("rand");
      hold = must_wait() && !flush;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
